// File: rtl/rom_arbiter.sv
// Two-port (fetch / load) round-robin arbiter in front of a combinational single-port ROM.
// Each port owns a one-entry response slot filled one cycle after its grant; a full, unaccepted slot blocks only its own port.
module rom_arbiter #(
  parameter logic [31:0] ROM_BYTES = 32'h0000_1000,
  parameter logic [31:0] FILL_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  input  logic        if_rready,
  output logic [31:0] if_rdata,
  output logic        if_err,
  input  logic        ls_req,
  input  logic [31:0] ls_addr,
  output logic        ls_gnt,
  output logic        ls_rvalid,
  input  logic        ls_rready,
  output logic [31:0] ls_rdata,
  output logic        ls_err,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_inst
);

  logic        last_ls_q, last_ls_d;
  logic        if_vld_q, if_vld_d;
  logic [31:0] if_dat_q, if_dat_d;
  logic        if_err_q, if_err_d;
  logic        ls_vld_q, ls_vld_d;
  logic [31:0] ls_dat_q, ls_dat_d;
  logic        ls_err_q, ls_err_d;

  logic        if_elig, ls_elig;
  logic        fault;
  logic [31:0] rsp_dat;

  // A port may be granted when its slot is empty or is being drained this same cycle.
  always_comb begin
    if_elig  = if_req & (~if_vld_q | if_rready);
    ls_elig  = ls_req & (~ls_vld_q | ls_rready);
    ls_gnt   = ~rst & ls_elig & (~if_elig | ~last_ls_q);
    if_gnt   = ~rst & if_elig & ~ls_gnt;
    rom_addr = ls_gnt ? ls_addr : if_addr;
    fault    = (rom_addr[1:0] != 2'b00) | (rom_addr >= ROM_BYTES);
    rsp_dat  = fault ? FILL_INST : rom_inst;
  end

  always_comb begin
    last_ls_d = last_ls_q;
    if_vld_d  = if_vld_q;
    if_dat_d  = if_dat_q;
    if_err_d  = if_err_q;
    ls_vld_d  = ls_vld_q;
    ls_dat_d  = ls_dat_q;
    ls_err_d  = ls_err_q;

    if (if_gnt || ls_gnt) begin
      last_ls_d = ls_gnt;
    end

    // A refill in the acceptance cycle wins over the clear, keeping rvalid high.
    if (if_gnt) begin
      if_vld_d = 1'b1;
      if_dat_d = rsp_dat;
      if_err_d = fault;
    end else if (if_vld_q && if_rready) begin
      if_vld_d = 1'b0;
    end

    if (ls_gnt) begin
      ls_vld_d = 1'b1;
      ls_dat_d = rsp_dat;
      ls_err_d = fault;
    end else if (ls_vld_q && ls_rready) begin
      ls_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_ls_q <= 1'b1;
      if_vld_q  <= 1'b0;
      if_dat_q  <= 32'h0;
      if_err_q  <= 1'b0;
      ls_vld_q  <= 1'b0;
      ls_dat_q  <= 32'h0;
      ls_err_q  <= 1'b0;
    end else begin
      last_ls_q <= last_ls_d;
      if_vld_q  <= if_vld_d;
      if_dat_q  <= if_dat_d;
      if_err_q  <= if_err_d;
      ls_vld_q  <= ls_vld_d;
      ls_dat_q  <= ls_dat_d;
      ls_err_q  <= ls_err_d;
    end
  end

  assign if_rvalid = if_vld_q;
  assign if_rdata  = if_dat_q;
  assign if_err    = if_err_q;
  assign ls_rvalid = ls_vld_q;
  assign ls_rdata  = ls_dat_q;
  assign ls_err    = ls_err_q;

endmodule

// File: tb/tb_rom_arbiter.sv
// Bench for rom_arbiter: directed cases plus a random run against a queue-based model of the arbitration rules.
module tb_rom_arbiter;

  localparam logic [31:0] ROM_BYTES = 32'h0000_1000;
  localparam logic [31:0] FILL      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0, ls_req = 1'b0;
  logic [31:0] if_addr = '0, ls_addr = '0;
  logic        if_rready = 1'b0, ls_rready = 1'b0;
  logic        if_gnt, ls_gnt, if_rvalid, ls_rvalid, if_err, ls_err;
  logic [31:0] if_rdata, ls_rdata, rom_addr, rom_inst;

  int n_checks = 0;
  int n_errors = 0;

  logic [32:0] ifq[$], lsq[$];
  logic [32:0] if_log[$], ls_log[$];
  bit          gnt_log[$];
  bit          last_ls_m = 1'b1;

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    case (a)
      32'h0:   rom_word = 32'h1000_02b7;
      32'h4:   rom_word = 32'h0210_0313;
      32'h8:   rom_word = 32'h0062_a023;
      32'hC:   rom_word = 32'h0000_006f;
      default: rom_word = {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
    endcase
  endfunction

  assign rom_inst = rom_word(rom_addr);

  function automatic logic [32:0] exp_rsp(input logic [31:0] a);
    bit bad;
    bad = (a % 4 != 0) || (a >= ROM_BYTES);
    exp_rsp = {bad, bad ? FILL : rom_word(a)};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  rom_arbiter #(.ROM_BYTES(ROM_BYTES), .FILL_INST(FILL)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rready(if_rready), .if_rdata(if_rdata), .if_err(if_err),
    .ls_req(ls_req), .ls_addr(ls_addr), .ls_gnt(ls_gnt),
    .ls_rvalid(ls_rvalid), .ls_rready(ls_rready), .ls_rdata(ls_rdata), .ls_err(ls_err),
    .rom_addr(rom_addr), .rom_inst(rom_inst)
  );

  // Reference model: each port has a queue of owed responses; a grant appends, a handshake removes.
  always @(negedge clk) begin
    int occ_if, occ_ls;
    bit if_el, ls_el, e_if, e_ls;
    if (rst) begin
      check_eq("rst_if_gnt", if_gnt, 0);
      check_eq("rst_ls_gnt", ls_gnt, 0);
      check_eq("rst_if_rvalid", if_rvalid, 0);
      check_eq("rst_ls_rvalid", ls_rvalid, 0);
      ifq.delete();
      lsq.delete();
      last_ls_m = 1'b1;
    end else begin
      occ_if = ifq.size();
      occ_ls = lsq.size();
      check_eq("if_rvalid", if_rvalid, occ_if != 0);
      check_eq("ls_rvalid", ls_rvalid, occ_ls != 0);
      if (if_rvalid && occ_if != 0) begin
        check_eq("if_rdata", if_rdata, ifq[0][31:0]);
        check_eq("if_err", if_err, ifq[0][32]);
        if (if_rready) begin
          if_log.push_back({if_err, if_rdata});
          void'(ifq.pop_front());
        end
      end
      if (ls_rvalid && occ_ls != 0) begin
        check_eq("ls_rdata", ls_rdata, lsq[0][31:0]);
        check_eq("ls_err", ls_err, lsq[0][32]);
        if (ls_rready) begin
          ls_log.push_back({ls_err, ls_rdata});
          void'(lsq.pop_front());
        end
      end
      if_el = if_req && (occ_if == 0 || if_rready);
      ls_el = ls_req && (occ_ls == 0 || ls_rready);
      e_ls  = ls_el && (!if_el || !last_ls_m);
      e_if  = if_el && !e_ls;
      check_eq("if_gnt", if_gnt, e_if);
      check_eq("ls_gnt", ls_gnt, e_ls);
      check_eq("gnt_excl", if_gnt & ls_gnt, 0);
      if (e_if) begin
        check_eq("rom_addr_if", rom_addr, if_addr);
        ifq.push_back(exp_rsp(if_addr));
        gnt_log.push_back(1'b0);
        last_ls_m = 1'b0;
      end else if (e_ls) begin
        check_eq("rom_addr_ls", rom_addr, ls_addr);
        lsq.push_back(exp_rsp(ls_addr));
        gnt_log.push_back(1'b1);
        last_ls_m = 1'b1;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    if_req = 1'b0;
    ls_req = 1'b0;
    step(1);
    rst = 1'b0;
    gnt_log.delete();
    if_log.delete();
    ls_log.delete();
  endtask

  function automatic logic [31:0] pick_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return {$urandom_range(0, 1023), 2'b00} | 32'($urandom_range(1, 3));
    if (r == 1) begin
      case ($urandom_range(0, 2))
        0:       return ROM_BYTES - 4;
        1:       return ROM_BYTES;
        default: return 32'hFFFF_FFFC;
      endcase
    end
    return {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] fetch_exp [4];
    logic [31:0] bad_addr  [3];
    int ls_cnt;
    fetch_exp = '{32'h1000_02b7, 32'h0210_0313, 32'h0062_a023, 32'h0000_006f};
    bad_addr  = '{32'h6, ROM_BYTES, 32'hFFFF_FFFC};

    #3;
    check_eq("rst_if_rdata", if_rdata, 0);
    check_eq("rst_ls_rdata", ls_rdata, 0);
    check_eq("rst_if_err_out", if_err, 0);
    check_eq("rst_ls_err_out", ls_err, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Fetch-only stream
    if_rready = 1'b1;
    ls_rready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if_req  = 1'b1;
      if_addr = 32'(i * 4);
      step(1);
    end
    if_req = 1'b0;
    step(2);
    check_eq("fetch_count", if_log.size(), 4);
    for (int i = 0; i < 4 && i < if_log.size(); i++) begin
      check_eq("fetch_data", if_log[i][31:0], fetch_exp[i]);
      check_eq("fetch_err", if_log[i][32], 0);
    end

    // Contention, alternating from IF after reset
    do_reset();
    if_req = 1'b1; ls_req = 1'b1;
    if_addr = 32'h0; ls_addr = 32'h4;
    step(4);
    if_req = 1'b0; ls_req = 1'b0;
    step(2);
    check_eq("cont_gnt_count", gnt_log.size(), 4);
    for (int i = 0; i < 4 && i < gnt_log.size(); i++)
      check_eq("cont_order", gnt_log[i], i % 2);
    check_eq("cont_if_data", if_log.size() > 0 ? if_log[0][31:0] : 32'hX, 32'h1000_02b7);
    check_eq("cont_ls_data", ls_log.size() > 0 ? ls_log[0][31:0] : 32'hX, 32'h0210_0313);

    // Load port blocked by backpressure; fetch port keeps flowing
    do_reset();
    if_rready = 1'b1; ls_rready = 1'b0;
    if_req = 1'b1; ls_req = 1'b1;
    if_addr = 32'hC; ls_addr = 32'h8;
    step(8);
    ls_cnt = 0;
    foreach (gnt_log[i]) ls_cnt += gnt_log[i];
    check_eq("bp_ls_grants", ls_cnt, 1);
    check_eq("bp_if_grants", gnt_log.size() - ls_cnt, 7);
    check_eq("bp_ls_rvalid", ls_rvalid, 1);
    check_eq("bp_ls_rdata", ls_rdata, 32'h0062_a023);
    ls_rready = 1'b1;
    @(negedge clk);
    check_eq("bp_release_ls_gnt", ls_gnt, 1);
    check_eq("bp_release_if_gnt", if_gnt, 0);
    step(1);
    check_eq("bp_refill_rvalid", ls_rvalid, 1);
    if_req = 1'b0; ls_req = 1'b0;
    step(3);

    // Faulting and boundary addresses
    do_reset();
    for (int i = 0; i < 3; i++) begin
      ls_req = 1'b1;
      ls_addr = bad_addr[i];
      step(1);
      ls_req = 1'b0;
      step(1);
    end
    if_req = 1'b1;
    if_addr = ROM_BYTES - 4;
    step(1);
    if_req = 1'b0;
    step(2);
    check_eq("fault_count", ls_log.size(), 3);
    for (int i = 0; i < 3 && i < ls_log.size(); i++) begin
      check_eq("fault_data", ls_log[i][31:0], FILL);
      check_eq("fault_err", ls_log[i][32], 1);
    end
    check_eq("edge_in_range_err", if_log.size() > 0 ? if_log[0][32] : 1'bX, 0);

    // Asynchronous reset with both slots full
    do_reset();
    if_rready = 1'b0; ls_rready = 1'b0;
    if_req = 1'b1; ls_req = 1'b1;
    if_addr = 32'h0; ls_addr = 32'h4;
    step(3);
    check_eq("full_if_rvalid", if_rvalid, 1);
    check_eq("full_ls_rvalid", ls_rvalid, 1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    if_req = 1'b0; ls_req = 1'b0;
    #1;
    check_eq("async_if_rvalid", if_rvalid, 0);
    check_eq("async_ls_rvalid", ls_rvalid, 0);
    #5;
    rst = 1'b0;
    #1;
    check_eq("post_rst_if_rvalid", if_rvalid, 0);
    check_eq("post_rst_ls_rvalid", ls_rvalid, 0);
    step(1);
    gnt_log.delete();
    if_rready = 1'b1; ls_rready = 1'b1;
    if_req = 1'b1; ls_req = 1'b1;
    step(1);
    check_eq("post_rst_first_tie", gnt_log.size() > 0 ? gnt_log[0] : 1'bX, 0);
    if_req = 1'b0; ls_req = 1'b0;
    step(2);

    // Random run against the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if_req    = ($urandom_range(0, 9) < 7);
      ls_req    = ($urandom_range(0, 9) < 6);
      if_rready = ($urandom_range(0, 9) < 6);
      ls_rready = ($urandom_range(0, 9) < 5);
      if_addr   = pick_addr();
      ls_addr   = pick_addr();
      step(1);
    end
    if_req = 1'b0; ls_req = 1'b0;
    if_rready = 1'b1; ls_rready = 1'b1;
    step(3);
    check_eq("drain_if", ifq.size(), 0);
    check_eq("drain_ls", lsq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
